// File: rtl/uart_tx_arbiter.sv
// Four-requester round-robin arbiter feeding a single 8N1 UART transmitter.
// One byte is taken from the winning requester per frame.
module uart_tx_arbiter #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 9600
) (
  input  logic        clk_50,
  input  logic        nRESET,
  input  logic [3:0]  req,
  input  logic [31:0] data_in,
  output logic [3:0]  grant,
  output logic [1:0]  cur_id,
  output logic        busy,
  output logic        txd
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic [1:0]    last_id;
  logic [1:0]    win;
  logic [1:0]    cand;
  logic          found;
  logic          tick;
  logic          take;

  assign busy = (state != IDLE);
  assign tick = busy && (cnt == CW'(DIV - 1));

  // Scan starts one past the last winner so every requester gets a turn.
  always_comb begin
    win   = last_id;
    cand  = last_id;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_id + 2'(k);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50 or negedge nRESET) begin
    if (!nRESET) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    take    = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_n = START;
          take    = 1'b1;
        end
      end
      START: if (tick) state_n = DATA;
      DATA:  if (tick && idx == 3'd7) state_n = STOP;
      STOP:  if (tick) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or negedge nRESET) begin
    if (!nRESET) begin
      grant   <= '0;
      cur_id  <= '0;
      last_id <= 2'd3;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      txd     <= 1'b1;
    end else begin
      grant <= '0;
      if (take) begin
        grant   <= 4'b0001 << win;
        shreg   <= data_in[{win, 3'b000} +: 8];
        cur_id  <= win;
        last_id <= win;
        cnt     <= '0;
        idx     <= '0;
        txd     <= 1'b0;
      end else if (busy) begin
        cnt <= tick ? '0 : cnt + 1'b1;
        if (tick) begin
          unique case (state)
            START: txd <= shreg[0];
            DATA: begin
              shreg <= shreg >> 1;
              idx   <= idx + 3'd1;
              txd   <= (idx == 3'd7) ? 1'b1 : shreg[1];
            end
            default: txd <= 1'b1;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table of request patterns plus
// hand sequences; grants and serial frames are scored against queues.
module tb_uart_tx_arbiter;

  localparam int CLK_HZ = 100;
  localparam int BAUD   = 10;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int FRAME  = 10 * DIV;

  logic        clk_50 = 1'b0;
  logic        nRESET = 1'b0;
  logic [3:0]  req    = '0;
  logic [31:0] data_in = '0;
  logic [3:0]  grant;
  logic [1:0]  cur_id;
  logic        busy;
  logic        txd;

  uart_tx_arbiter #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk_50 (clk_50),
    .nRESET (nRESET),
    .req    (req),
    .data_in(data_in),
    .grant  (grant),
    .cur_id (cur_id),
    .busy   (busy),
    .txd    (txd)
  );

  always #5 clk_50 = ~clk_50;

  typedef struct {
    logic [1:0] id;
    logic [7:0] b;
  } exp_t;

  typedef struct {
    logic [3:0]       req;
    logic [31:0]      data;
    int               nfr;
    logic [4:0][1:0]  ids;
  } vec_t;

  exp_t       exp_q[$];
  logic [7:0] rx_q[$];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int n_grant = 0;
  int last_g = -1;
  bit gap_chk = 0;

  bit         rx_on = 0;
  int         rx_t = 0;
  int         rx_err = 0;
  logic [9:0] frm = '0;
  logic       prev_txd = 1'b1;
  int         busy_run = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: grant scoreboard, per-cycle frame check, busy length.
  always @(negedge clk_50) begin
    cyc++;
    if (!nRESET) begin
      rx_on    = 0;
      busy_run = 0;
      prev_txd = 1'b1;
      rx_q.delete();
    end else begin
      if (grant != 4'b0000) begin
        n_grant++;
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", int'(grant), 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("grant", int'(grant), int'(4'b0001 << e.id));
          chk("cur_id", int'(cur_id), int'(e.id));
          rx_q.push_back(e.b);
        end
        if (gap_chk && last_g >= 0) chk("grant_gap", cyc - last_g, FRAME + 1);
        last_g = cyc;
      end
      if (!rx_on && prev_txd && !txd) begin
        rx_on  = 1;
        rx_t   = 0;
        rx_err = 0;
        if (rx_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
          frm = 10'h3FF;
        end else begin
          frm = {1'b1, rx_q[0], 1'b0};
        end
      end
      if (rx_on) begin
        if (txd !== frm[rx_t / DIV]) rx_err++;
        if (rx_t == FRAME - 1) begin
          chk("frame_bits", rx_err, 0);
          if (rx_q.size() > 0) void'(rx_q.pop_front());
          rx_on = 0;
        end
        rx_t++;
      end
      if (busy) begin
        busy_run++;
      end else if (busy_run > 0) begin
        chk("busy_len", busy_run, FRAME);
        busy_run = 0;
      end
      prev_txd = txd;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_50);
    #1;
  endtask

  task automatic wait_grants(input int n, input int budget);
    int g0;
    int t;
    g0 = n_grant;
    t = 0;
    while (n_grant - g0 < n && t < budget) begin
      step(1);
      t++;
    end
    if (n_grant - g0 < n) chk("grant_timeout", n_grant - g0, n);
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while (busy && t < budget) begin
      step(1);
      t++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{req: 4'b1111, data: 32'h44332211, nfr: 5,
                ids: {2'd0, 2'd3, 2'd2, 2'd1, 2'd0}};
    vecs[1] = '{req: 4'b0001, data: 32'h000000A5, nfr: 2,
                ids: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0}};
    vecs[2] = '{req: 4'b0100, data: 32'h003C0000, nfr: 1,
                ids: {2'd0, 2'd0, 2'd0, 2'd0, 2'd2}};
    vecs[3] = '{req: 4'b0011, data: 32'h0000C35A, nfr: 2,
                ids: {2'd0, 2'd0, 2'd0, 2'd1, 2'd0}};
    vecs[4] = '{req: 4'b1010, data: 32'h7E008100, nfr: 3,
                ids: {2'd0, 2'd0, 2'd3, 2'd1, 2'd3}};

    step(3);
    chk("rst_txd", int'(txd), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_grant", int'(grant), 0);
    chk("rst_cur_id", int'(cur_id), 0);
    nRESET = 1'b1;
    step(2);

    for (int i = 0; i < 5; i++) begin
      int g0;
      g0 = n_grant;
      for (int k = 0; k < vecs[i].nfr; k++) begin
        exp_t e;
        e.id = vecs[i].ids[k];
        e.b  = vecs[i].data[8*e.id +: 8];
        exp_q.push_back(e);
      end
      gap_chk = 1;
      last_g  = -1;
      req     = vecs[i].req;
      data_in = vecs[i].data;
      wait_grants(vecs[i].nfr, (FRAME + 10) * vecs[i].nfr + 10);
      req = '0;
      wait_idle(FRAME + 20);
      gap_chk = 0;
      step(3);
      chk("vec_grants", n_grant - g0, vecs[i].nfr);
    end

    // Late request raised mid-frame is served right after the stop bit.
    exp_q.push_back('{id: 2'd2, b: 8'h96});
    exp_q.push_back('{id: 2'd1, b: 8'h69});
    gap_chk = 1;
    last_g  = -1;
    req     = 4'b0100;
    data_in = 32'h0096_6900;
    wait_grants(1, 20);
    req = '0;
    step(40);
    req = 4'b0010;
    wait_grants(1, FRAME + 20);
    req = '0;
    wait_idle(FRAME + 20);
    gap_chk = 0;
    step(3);

    // Request withdrawn before the frame ends must leave no trace.
    begin
      int g0;
      exp_q.push_back('{id: 2'd0, b: 8'hF0});
      req     = 4'b0001;
      data_in = 32'h0000_55F0;
      wait_grants(1, 20);
      req = '0;
      step(30);
      req = 4'b0010;
      step(20);
      req = '0;
      g0 = n_grant;
      wait_idle(FRAME + 20);
      step(30);
      chk("withdrawn_grants", n_grant - g0, 0);
      chk("withdrawn_txd", int'(txd), 1);
      chk("withdrawn_busy", int'(busy), 0);
    end

    // Reset in the middle of a 0x00 frame, then a clean frame from req 3.
    exp_q.push_back('{id: 2'd0, b: 8'h00});
    req     = 4'b0001;
    data_in = 32'h0000_0000;
    wait_grants(1, 20);
    req = '0;
    step(44);
    nRESET  = 1'b0;
    req     = 4'b1000;
    data_in = 32'hD200_0000;
    #1;
    chk("abort_txd", int'(txd), 1);
    chk("abort_busy", int'(busy), 0);
    exp_q.push_back('{id: 2'd3, b: 8'hD2});
    step(3);
    chk("abort_grant", int'(grant), 0);
    chk("abort_cur_id", int'(cur_id), 0);
    nRESET = 1'b1;
    #1;
    chk("release_grant", int'(grant), 0);
    wait_grants(1, 20);
    req = '0;
    wait_idle(FRAME + 20);
    step(5);

    chk("queues_drained", exp_q.size() + rx_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
